// File: rtl/run_detect_pkg.sv
// rtl/run_detect_pkg.sv - shared types and defaults for the run-detect scheduler
package run_detect_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_WIN   = 16;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        CAP    = 5'b00010,
        CMP    = 5'b00100,
        SETTLE = 5'b01000,
        RPT    = 5'b10000
    } sched_state_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/run_detect_sched_if.sv
// rtl/run_detect_sched_if.sv - requester-side request/ack/result bundle
interface run_detect_sched_if
    import run_detect_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W
);
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   ack;
    logic [CNT_W-1:0] rslt;
    logic             rslt_vld;

    modport master (output req, input ack, input rslt, input rslt_vld);
    modport slave  (input req, output ack, output rslt, output rslt_vld);
endinterface

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin pick starting at rr_ptr
module rr_arb #(
    parameter int NCH = 4,
    localparam int IDX_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);
    logic [IDX_W-1:0] sel;

    // Walk from the farthest offset back to rr_ptr so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        sel     = '0;
        any_req = |req;
        for (int k = NCH - 1; k >= 0; k--) begin
            sel = IDX_W'((int'(rr_ptr) + k) % NCH);
            if (req[sel]) begin
                gnt_idx = sel;
            end
        end
    end
endmodule

// File: rtl/run_detect_sched.sv
// rtl/run_detect_sched.sv - time-shares one run-detect datapath among NCH channels
module run_detect_sched
    import run_detect_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int WIN   = DEF_WIN,
    parameter int CNT_W = DEF_CNT_W,
    localparam int SEL_W = $clog2(NCH),
    localparam int WC_W  = $clog2(WIN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    run_detect_sched_if.slave  bus,
    input  logic               smpl_vld,
    input  logic [CNT_W-1:0]   N_abv,
    output logic [SEL_W-1:0]   ch_sel,
    output logic               strtCapCmp,
    output logic               busy
);
    sched_state_t     state, state_nxt;
    logic [SEL_W-1:0] rr_ptr;
    logic [WC_W-1:0]  win_cnt;
    logic [NCH-1:0]   ack_q;
    logic [CNT_W-1:0] rslt_q;
    logic             rslt_vld_q;

    logic [SEL_W-1:0] gnt_idx;
    logic             any_req;
    logic             req_cur;
    logic             win_last;
    logic             grant;
    logic             win_inc;
    logic             release_grant;

    rr_arb #(.NCH(NCH)) u_arb (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign req_cur  = bus.req[ch_sel];
    assign win_last = (win_cnt == WC_W'(WIN - 1));
    assign busy     = (state != IDLE);

    assign bus.ack      = ack_q;
    assign bus.rslt     = rslt_q;
    assign bus.rslt_vld = rslt_vld_q;

    // A dropped request beats a coincident sample strobe: the grant is abandoned.
    always_comb begin
        state_nxt     = state;
        strtCapCmp    = 1'b0;
        grant         = 1'b0;
        win_inc       = 1'b0;
        release_grant = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = CAP;
                end
            end
            CAP: begin
                if (!req_cur) begin
                    release_grant = 1'b1;
                    state_nxt     = IDLE;
                end else if (smpl_vld) begin
                    strtCapCmp = 1'b1;
                    state_nxt  = CMP;
                end
            end
            CMP: begin
                if (!req_cur) begin
                    release_grant = 1'b1;
                    state_nxt     = IDLE;
                end else if (smpl_vld) begin
                    win_inc = 1'b1;
                    if (win_last) begin
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                state_nxt = RPT;
            end
            RPT: begin
                release_grant = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result registers load at the end of SETTLE so ack/rslt_vld/rslt are all valid during RPT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_sel     <= '0;
            rr_ptr     <= '0;
            win_cnt    <= '0;
            ack_q      <= '0;
            rslt_q     <= '0;
            rslt_vld_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            ack_q      <= '0;
            rslt_vld_q <= 1'b0;
            if (grant) begin
                ch_sel <= gnt_idx;
            end
            if (strtCapCmp) begin
                win_cnt <= '0;
            end else if (win_inc) begin
                win_cnt <= win_cnt + 1'b1;
            end
            if (release_grant) begin
                rr_ptr <= SEL_W'(wrap_inc(32'(ch_sel), NCH));
            end
            if (state == SETTLE) begin
                ack_q      <= NCH'(1) << ch_sel;
                rslt_q     <= N_abv;
                rslt_vld_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_run_detect_sched.sv
// tb/tb_run_detect_sched.sv - directed and randomized checks of run_detect_sched
module tb_run_detect_sched;
    localparam int NCH = 4;
    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       smpl_vld;
    logic [7:0] N_abv;
    logic [1:0] ch_sel;
    logic       strt;
    logic       busy;

    logic       smpl1;
    logic [7:0] nabv1;
    logic [1:0] ch_sel1;
    logic       strt1;
    logic       busy1;

    int n_assert = 0;
    int n_fail   = 0;
    int model_ptr;
    logic [7:0] last_rslt;

    run_detect_sched_if #(.NCH(NCH), .CNT_W(8)) bus0 ();
    run_detect_sched_if #(.NCH(NCH), .CNT_W(8)) bus1 ();

    run_detect_sched #(.NCH(NCH), .WIN(WIN), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus0),
        .smpl_vld   (smpl_vld),
        .N_abv      (N_abv),
        .ch_sel     (ch_sel),
        .strtCapCmp (strt),
        .busy       (busy)
    );

    run_detect_sched #(.NCH(NCH), .WIN(1), .CNT_W(8)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus1),
        .smpl_vld   (smpl1),
        .N_abv      (nabv1),
        .ch_sel     (ch_sel1),
        .strtCapCmp (strt1),
        .busy       (busy1)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (r[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    // Starts and ends on a falling edge with the scheduler idle. abort_at is the
    // strobe index (0 = capture strobe) replaced by dropping the request; -1 = none.
    task automatic run_grant(input logic [3:0] reqv, input int gap_fix,
                             input logic [7:0] nfinal, input int abort_at, input bit keep);
        int exp_ch;
        int gap;
        exp_ch   = pick(reqv, model_ptr);
        bus0.req = reqv;
        smpl_vld = 1'b0;
        @(negedge clk);
        #1;
        chk("grant_busy", busy, 1);
        chk("grant_ch_sel", ch_sel, exp_ch);
        for (int s = 0; s <= WIN; s++) begin
            gap = (gap_fix >= 0) ? gap_fix : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                smpl_vld = 1'b0;
                N_abv    = 8'($urandom);
                #1;
                chk("gap_strt", strt, 0);
                chk("gap_ack", bus0.ack, 0);
                @(negedge clk);
            end
            if (s == abort_at) begin
                bus0.req[exp_ch] = 1'b0;
                smpl_vld = 1'b0;
                #1;
                chk("abort_busy_before", busy, 1);
                @(negedge clk);
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_ack", bus0.ack, 0);
                chk("abort_vld", bus0.rslt_vld, 0);
                chk("abort_rslt", bus0.rslt, last_rslt);
                model_ptr = (exp_ch + 1) % NCH;
                return;
            end
            smpl_vld = 1'b1;
            N_abv    = 8'($urandom);
            #1;
            chk("strobe_strt", strt, (s == 0) ? 1 : 0);
            chk("strobe_ack", bus0.ack, 0);
            chk("strobe_ch_sel", ch_sel, exp_ch);
            @(negedge clk);
        end
        smpl_vld = 1'($urandom);
        N_abv    = nfinal;
        #1;
        chk("settle_ack", bus0.ack, 0);
        chk("settle_vld", bus0.rslt_vld, 0);
        chk("settle_strt", strt, 0);
        @(negedge clk);
        smpl_vld = 1'($urandom);
        N_abv    = 8'($urandom);
        #1;
        chk("rpt_ack", bus0.ack, 32'(1) << exp_ch);
        chk("rpt_vld", bus0.rslt_vld, 1);
        chk("rpt_rslt", bus0.rslt, nfinal);
        chk("rpt_strt", strt, 0);
        @(negedge clk);
        smpl_vld = 1'b0;
        #1;
        chk("post_ack", bus0.ack, 0);
        chk("post_vld", bus0.rslt_vld, 0);
        chk("post_busy", busy, 0);
        chk("post_rslt", bus0.rslt, nfinal);
        last_rslt = nfinal;
        model_ptr = (exp_ch + 1) % NCH;
        if (!keep) bus0.req[exp_ch] = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus0.req  = '0;
        bus1.req  = '0;
        smpl_vld  = 1'b0;
        smpl1     = 1'b0;
        N_abv     = '0;
        nabv1     = '0;
        model_ptr = 0;
        last_rslt = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_strt", strt, 0);
        chk("rst_ack", bus0.ack, 0);
        chk("rst_rslt", bus0.rslt, 0);
        chk("rst_vld", bus0.rslt_vld, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single channel, strobe every third cycle, then wrap from rr_ptr=3
        run_grant(4'b0100, 2, 8'd7, -1, 1'b0);
        run_grant(4'b0011, -1, 8'h3c, -1, 1'b0);
        run_grant(4'b0010, -1, 8'h51, -1, 1'b0);

        // abort after five window strobes, then continuous contention
        run_grant(4'b0010, 1, 8'h00, 6, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_grant(4'b1111, -1, 8'($urandom), -1, 1'b1);
        end

        for (int i = 0; i < 10; i++) begin
            logic [3:0] r;
            int ab;
            r  = 4'($urandom_range(1, 15));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIN)) : -1;
            run_grant(r, -1, 8'($urandom), ab, 1'($urandom));
        end

        // asynchronous reset in the middle of a compare window
        bus0.req = 4'b0100;
        smpl_vld = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            smpl_vld = 1'b1;
            @(negedge clk);
        end
        smpl_vld = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ch_sel", ch_sel, 0);
        chk("arst_strt", strt, 0);
        chk("arst_ack", bus0.ack, 0);
        chk("arst_vld", bus0.rslt_vld, 0);
        chk("arst_rslt", bus0.rslt, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_ptr = 0;
        last_rslt = '0;
        run_grant(4'b0001, -1, 8'h9a, -1, 1'b0);

        // WIN=1 instance with a strobe every cycle
        for (int i = 0; i < 2; i++) begin
            logic [7:0] k;
            k = 8'($urandom);
            @(negedge clk);
            bus1.req = 4'(1 << i);
            smpl1    = 1'b1;
            #1;
            chk("w1_idle_strt", strt1, 0);
            chk("w1_idle_busy", busy1, 0);
            @(negedge clk);
            #1;
            chk("w1_cap_strt", strt1, 1);
            chk("w1_cap_ch_sel", ch_sel1, i);
            @(negedge clk);
            #1;
            chk("w1_cmp_strt", strt1, 0);
            chk("w1_cmp_ack", bus1.ack, 0);
            @(negedge clk);
            nabv1 = k;
            #1;
            chk("w1_settle_ack", bus1.ack, 0);
            chk("w1_settle_busy", busy1, 1);
            @(negedge clk);
            nabv1 = 8'($urandom);
            #1;
            chk("w1_rpt_ack", bus1.ack, 32'(1) << i);
            chk("w1_rpt_vld", bus1.rslt_vld, 1);
            chk("w1_rpt_rslt", bus1.rslt, k);
            @(negedge clk);
            bus1.req = '0;
            #1;
            chk("w1_post_ack", bus1.ack, 0);
            chk("w1_post_busy", busy1, 0);
        end
        smpl1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
